// File: rtl/boot_ctrl_pkg.sv
// Shared types and elaboration helpers for the multi-hart boot/exit sequencer.
// Parameter legality is computed here so the top can reject bad configurations at elaboration.
package boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_STAGGER = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } boot_state_e;

  // Counter value at which the last hart's fetch enable is raised.
  function automatic int unsigned stagger_len(input int unsigned num_harts,
                                              input int unsigned stagger_cycles);
    return (num_harts - 1) * stagger_cycles;
  endfunction

  function automatic bit fits_cnt(input longint unsigned value, input int unsigned cnt_w);
    return (cnt_w >= 64) || (value < (64'd1 << cnt_w));
  endfunction

  function automatic bit params_legal(input int unsigned num_harts,
                                      input int unsigned rst_hold_cycles,
                                      input int unsigned stagger_cycles,
                                      input int unsigned timeout_cycles,
                                      input int unsigned cnt_w);
    return (num_harts >= 1) && (rst_hold_cycles >= 1) && (cnt_w >= 1) &&
           fits_cnt(longint'(rst_hold_cycles), cnt_w) &&
           fits_cnt(longint'(stagger_len(num_harts, stagger_cycles)), cnt_w) &&
           fits_cnt(longint'(timeout_cycles), cnt_w);
  endfunction

endpackage

// File: rtl/boot_ctrl_cnt.sv
// Clearable, saturating cycle counter with an equality compare against a terminal value.
// Clear has priority over increment; the count sticks at all-ones instead of wrapping.
module boot_ctrl_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // NOTE: cnt_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/multi_hart_boot_ctrl.sv
// Boot and exit sequencer: holds hart resets, staggers fetch enables, then aggregates
// per-hart exit reports (with optional watchdog) into one exit_valid/exit_zero pair.
module multi_hart_boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int unsigned NUM_HARTS       = 2,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fetch_enable_i,
  input  logic [NUM_HARTS-1:0] hart_exit_valid_i,
  input  logic [NUM_HARTS-1:0] hart_exit_zero_i,
  output logic [NUM_HARTS-1:0] hart_rst_no,
  output logic [NUM_HARTS-1:0] hart_fetch_enable_o,
  output logic [NUM_HARTS-1:0] exit_mask_o,
  output logic                 exit_valid_o,
  output logic                 exit_zero_o,
  output logic                 timeout_o,
  output logic [2:0]           state_o
);

  if (!params_legal(NUM_HARTS, RST_HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES, CNT_W))
  begin : g_bad_params
    $error("multi_hart_boot_ctrl: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(stagger_len(NUM_HARTS, STAGGER_CYCLES));
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_HARTS-1:0] ALL_HARTS = '1;

  boot_state_e          state_d, state_q;
  logic [NUM_HARTS-1:0] rst_n_d, rst_n_q;
  logic [NUM_HARTS-1:0] fetch_d, fetch_q;
  logic [NUM_HARTS-1:0] mask_d, mask_q;
  logic [NUM_HARTS-1:0] zero_d, zero_q;
  logic                 exit_valid_d, exit_valid_q;
  logic                 exit_zero_d, exit_zero_q;
  logic                 timeout_d, timeout_q;

  logic [NUM_HARTS-1:0] exit_seen, new_exit;
  logic                 cnt_clr, cnt_inc, cnt_hit;
  logic [CNT_W-1:0]     cnt_term, cnt_val;

  boot_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_i (cnt_term),
    .cnt_o  (cnt_val),
    .hit_o  (cnt_hit)
  );

  always_comb begin
    state_d      = state_q;
    rst_n_d      = rst_n_q;
    fetch_d      = fetch_q;
    exit_valid_d = exit_valid_q;
    exit_zero_d  = exit_zero_q;
    timeout_d    = timeout_q;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    cnt_term     = '0;

    // Only harts that are fetching may report; a zero flag is latched on the first report only.
    exit_seen = hart_exit_valid_i & fetch_q;
    new_exit  = exit_seen & ~mask_q;
    mask_d    = mask_q | exit_seen;
    zero_d    = zero_q | (new_exit & hart_exit_zero_i);

    case (state_q)
      ST_IDLE: begin
        rst_n_d      = '0;
        fetch_d      = '0;
        mask_d       = '0;
        zero_d       = '0;
        exit_valid_d = 1'b0;
        exit_zero_d  = 1'b0;
        timeout_d    = 1'b0;
        cnt_clr      = 1'b1;
        if (fetch_enable_i) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        cnt_inc  = 1'b1;
        cnt_term = HOLD_LAST;
        if (cnt_hit) begin
          rst_n_d = '1;
          state_d = ST_STAGGER;
          cnt_clr = 1'b1;
        end
      end
      ST_STAGGER: begin
        cnt_inc  = 1'b1;
        cnt_term = STAGGER_LAST;
        for (int unsigned k = 0; k < NUM_HARTS; k++) begin
          if (cnt_val == CNT_W'(STAGGER_CYCLES * k)) begin
            fetch_d[k] = 1'b1;
          end
        end
        if (cnt_hit) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_inc  = 1'b1;
        cnt_term = TIMEOUT_LAST;
        if (mask_d == ALL_HARTS) begin
          state_d      = ST_DONE;
          exit_valid_d = 1'b1;
          exit_zero_d  = &zero_d;
          timeout_d    = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && cnt_hit) begin
          state_d      = ST_DONE;
          exit_valid_d = 1'b1;
          exit_zero_d  = 1'b0;
          timeout_d    = 1'b1;
        end
      end
      ST_DONE: begin
        // Aggregated result stays frozen; only the mask keeps tracking late exits.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping the request from any active state returns to IDLE without an exit report.
    if (!fetch_enable_i && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      rst_n_d      = '0;
      fetch_d      = '0;
      mask_d       = '0;
      zero_d       = '0;
      exit_valid_d = 1'b0;
      exit_zero_d  = 1'b0;
      timeout_d    = 1'b0;
      cnt_clr      = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rst_n_q      <= '0;
      fetch_q      <= '0;
      mask_q       <= '0;
      zero_q       <= '0;
      exit_valid_q <= 1'b0;
      exit_zero_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_n_q      <= rst_n_d;
      fetch_q      <= fetch_d;
      mask_q       <= mask_d;
      zero_q       <= zero_d;
      exit_valid_q <= exit_valid_d;
      exit_zero_q  <= exit_zero_d;
      timeout_q    <= timeout_d;
    end
  end

  assign hart_rst_no         = rst_n_q;
  assign hart_fetch_enable_o = fetch_q;
  assign exit_mask_o         = mask_q;
  assign exit_valid_o        = exit_valid_q;
  assign exit_zero_o         = exit_zero_q;
  assign timeout_o           = timeout_q;
  assign state_o             = state_q;

endmodule
